// File: rtl/op_token_queue.sv
// op_token_queue: classifies incoming ASCII characters against a small operator
// table and queues the resulting op codes in a show-ahead FIFO for the ALU
// sequencer. Whitespace can be skipped; unknown characters raise a one-cycle
// error pulse and bump a saturating error counter.
module op_token_queue #(
    parameter int                        DATA_W     = 8,
    parameter int                        NUM_OPS    = 4,
    parameter logic [NUM_OPS*DATA_W-1:0] OP_CHARS   = {8'h2F, 8'h2A, 8'h2D, 8'h2B},
    parameter int                        CODE_W     = 8,
    parameter int                        FIFO_DEPTH = 4,
    parameter bit                        SKIP_SPACE = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             op,
    input  logic                          i_ready,
    output logic                          i_ack,
    output logic [CODE_W-1:0]             op_code,
    output logic                          o_ready,
    input  logic                          o_ack,
    output logic                          err,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              match_found;
    logic [CODE_W-1:0] match_code;
    logic              is_space;
    logic              accept;
    logic              push;
    logic              pop;
    logic              unknown;

    // Handshake and output view are taken from registered state only, so a pop
    // never opens the input in the same cycle.
    assign i_ack     = (level_q != LVL_W'(FIFO_DEPTH));
    assign o_ready   = (level_q != '0);
    assign op_code   = o_ready ? mem_q[rd_ptr_q] : '0;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign level     = level_q;

    // Table lookup: scanning from the top down lets the lowest matching index win.
    always_comb begin
        match_found = 1'b0;
        match_code  = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (op == OP_CHARS[i*DATA_W +: DATA_W]) begin
                match_found = 1'b1;
                match_code  = CODE_W'(i + 1);
            end
        end
        is_space = SKIP_SPACE && ((op == DATA_W'(8'h20)) || (op == DATA_W'(8'h09)) ||
                                  (op == DATA_W'(8'h0A)) || (op == DATA_W'(8'h0D)));
    end

    // Next-state for pointers, occupancy and error reporting.
    always_comb begin
        accept      = i_ready && i_ack;
        push        = accept && match_found;
        unknown     = accept && !match_found && !is_space;
        pop         = o_ready && o_ack;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        err_d       = unknown;
        err_count_d = err_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (unknown && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Storage write: only the slot at the write pointer changes on a push.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = match_code;
        end
    end

    // Control state with synchronous active-low reset; reset drops queued entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
